// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the UART core.
//   OVERSAMPLE        : ticks per serial bit
//   START_SAMPLE_TICK : tick within the start bit at which the receiver checks the line
package uart_pkg;

  localparam int unsigned OVERSAMPLE        = 16;
  localparam int unsigned START_SAMPLE_TICK = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready on both sides.
//   clk, reset          : clock, synchronous active-high reset
//   in_data/in_valid    : write side; push when in_valid && in_ready
//   in_ready            : not full (stays low while full, even if a pop happens)
//   out_data/out_valid  : head of queue (zero while empty); pop when out_valid && out_ready
//   count               : occupancy, 0..DEPTH
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop;

  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_core.sv
// Single-clock UART with FIFO-buffered transmitter and receiver.
//   clk, reset                     : clock, synchronous active-high reset
//   parity_enable, parity_type     : parity present; 0 even / 1 odd
//   two_stop_bits                  : transmitter sends two stop bits
//   loopback                       : receiver fed from internal TX line, serial_out held high
//   baud_div                       : clk cycles per oversample tick (0 behaves as 1)
//   tx_data/tx_valid/tx_ready      : TX FIFO write side
//   tx_fifo_count, tx_busy         : TX occupancy; frame in progress or data pending
//   serial_out, serial_in          : pad lines (serial_in is asynchronous)
//   rx_data/rx_*_error/rx_valid    : head of RX FIFO with per-word flags
//   rx_ready                       : RX FIFO pop
//   rx_fifo_count, rx_overrun      : RX occupancy; pulse when a word is dropped
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          parity_enable,
  input  logic                          parity_type,
  input  logic                          two_stop_bits,
  input  logic                          loopback,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count,
  output logic                          tx_busy,
  output logic                          serial_out,
  input  logic                          serial_in,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_parity_error,
  output logic                          rx_frame_error,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count,
  output logic                          rx_overrun
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_WIDTH);
  localparam logic [TickW-1:0] LastTick  = TickW'(OVERSAMPLE - 1);
  localparam logic [TickW-1:0] StartTick = TickW'(START_SAMPLE_TICK - 1);
  localparam logic [BitW-1:0]  LastBit   = BitW'(DATA_WIDTH - 1);

  // Terminal divider count; baud_div of 0 behaves like 1.
  logic [DIV_WIDTH-1:0] baud_last;
  assign baud_last = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);

  // ---------------------------------------------------------------- TX
  logic [DATA_WIDTH-1:0] tx_fifo_data;
  logic                  tx_fifo_valid, tx_pop;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_data   (tx_data),
    .in_valid  (tx_valid),
    .in_ready  (tx_ready),
    .out_data  (tx_fifo_data),
    .out_valid (tx_fifo_valid),
    .out_ready (tx_pop),
    .count     (tx_fifo_count)
  );

  tx_state_t             tx_state_q;
  logic [DIV_WIDTH-1:0]  tx_div_cnt_q, tx_div_last_q;
  logic [TickW-1:0]      tx_tick_cnt_q;
  logic [BitW-1:0]       tx_bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic                  tx_parity_q, tx_par_en_q, tx_two_stop_q, tx_line_q;
  logic                  tx_tick, tx_bit_end, tx_frame_done;

  assign tx_tick       = (tx_state_q != TX_IDLE) && (tx_div_cnt_q == tx_div_last_q);
  assign tx_bit_end    = tx_tick && (tx_tick_cnt_q == LastTick);
  assign tx_frame_done = tx_bit_end && ((tx_state_q == TX_STOP && !tx_two_stop_q) ||
                                        tx_state_q == TX_STOP2);
  // Popping at the end of the last stop bit chains frames without an idle gap.
  assign tx_pop        = tx_fifo_valid && (tx_state_q == TX_IDLE || tx_frame_done);
  assign tx_busy       = (tx_state_q != TX_IDLE) || tx_fifo_valid;
  assign serial_out    = loopback ? 1'b1 : tx_line_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q    <= TX_IDLE;
      tx_div_cnt_q  <= '0;
      tx_div_last_q <= '0;
      tx_tick_cnt_q <= '0;
      tx_bit_cnt_q  <= '0;
      tx_shift_q    <= '0;
      tx_parity_q   <= 1'b0;
      tx_par_en_q   <= 1'b0;
      tx_two_stop_q <= 1'b0;
      tx_line_q     <= 1'b1;
    end else begin
      if (tx_tick) begin
        tx_div_cnt_q  <= '0;
        tx_tick_cnt_q <= tx_tick_cnt_q + TickW'(1);
      end else if (tx_state_q != TX_IDLE) begin
        tx_div_cnt_q  <= tx_div_cnt_q + DIV_WIDTH'(1);
      end

      if (tx_pop) begin
        tx_state_q    <= TX_START;
        tx_line_q     <= 1'b0;
        tx_shift_q    <= tx_fifo_data;
        tx_parity_q   <= ^tx_fifo_data ^ parity_type;
        tx_par_en_q   <= parity_enable;
        tx_two_stop_q <= two_stop_bits;
        tx_div_last_q <= baud_last;
        tx_div_cnt_q  <= '0;
        tx_tick_cnt_q <= '0;
      end else if (tx_bit_end) begin
        unique case (tx_state_q)
          TX_START: begin
            tx_state_q   <= TX_DATA;
            tx_line_q    <= tx_shift_q[0];
            tx_bit_cnt_q <= '0;
          end
          TX_DATA: begin
            if (tx_bit_cnt_q == LastBit) begin
              tx_state_q <= tx_par_en_q ? TX_PARITY : TX_STOP;
              tx_line_q  <= tx_par_en_q ? tx_parity_q : 1'b1;
            end else begin
              tx_bit_cnt_q <= tx_bit_cnt_q + BitW'(1);
              tx_shift_q   <= tx_shift_q >> 1;
              tx_line_q    <= tx_shift_q[1];
            end
          end
          TX_PARITY: begin
            tx_state_q <= TX_STOP;
            tx_line_q  <= 1'b1;
          end
          TX_STOP: begin
            tx_state_q <= tx_two_stop_q ? TX_STOP2 : TX_IDLE;
            tx_line_q  <= 1'b1;
          end
          default: begin
            tx_state_q <= TX_IDLE;
            tx_line_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- RX
  logic rx_sync1_q, rx_sync2_q, rx_prev_q, rx_line;

  // Loopback takes the registered TX line, so no synchronizer is needed there.
  assign rx_line = loopback ? tx_line_q : rx_sync2_q;

  rx_state_t             rx_state_q;
  logic [DIV_WIDTH-1:0]  rx_div_cnt_q, rx_div_last_q;
  logic [TickW-1:0]      rx_tick_cnt_q;
  logic [BitW-1:0]       rx_bit_cnt_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic                  rx_par_bit_q, rx_par_en_q, rx_par_type_q, rx_overrun_q;
  logic                  rx_tick, rx_sample, rx_push, rx_fifo_ready, rx_perr;
  logic [DATA_WIDTH+1:0] rx_fifo_in, rx_fifo_out;

  assign rx_tick    = (rx_state_q != RX_IDLE) && (rx_div_cnt_q == rx_div_last_q);
  assign rx_sample  = rx_tick &&
                      (rx_tick_cnt_q == ((rx_state_q == RX_START) ? StartTick : LastTick));
  assign rx_push    = rx_sample && (rx_state_q == RX_STOP);
  assign rx_perr    = rx_par_en_q && (rx_par_bit_q != (^rx_shift_q ^ rx_par_type_q));
  assign rx_fifo_in = {~rx_line, rx_perr, rx_shift_q};

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_data   (rx_fifo_in),
    .in_valid  (rx_push),
    .in_ready  (rx_fifo_ready),
    .out_data  (rx_fifo_out),
    .out_valid (rx_valid),
    .out_ready (rx_ready),
    .count     (rx_fifo_count)
  );

  assign rx_data         = rx_fifo_out[DATA_WIDTH-1:0];
  assign rx_parity_error = rx_fifo_out[DATA_WIDTH];
  assign rx_frame_error  = rx_fifo_out[DATA_WIDTH+1];
  assign rx_overrun      = rx_overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync1_q    <= 1'b1;
      rx_sync2_q    <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      rx_div_cnt_q  <= '0;
      rx_div_last_q <= '0;
      rx_tick_cnt_q <= '0;
      rx_bit_cnt_q  <= '0;
      rx_shift_q    <= '0;
      rx_par_bit_q  <= 1'b0;
      rx_par_en_q   <= 1'b0;
      rx_par_type_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      rx_sync1_q   <= serial_in;
      rx_sync2_q   <= rx_sync1_q;
      rx_prev_q    <= rx_line;
      rx_overrun_q <= rx_push && !rx_fifo_ready;

      if (rx_tick) begin
        rx_div_cnt_q  <= '0;
        rx_tick_cnt_q <= rx_tick_cnt_q + TickW'(1);
      end else if (rx_state_q != RX_IDLE) begin
        rx_div_cnt_q  <= rx_div_cnt_q + DIV_WIDTH'(1);
      end

      if (rx_state_q == RX_IDLE) begin
        if (rx_prev_q && !rx_line) begin
          rx_state_q    <= RX_START;
          rx_div_cnt_q  <= '0;
          rx_tick_cnt_q <= '0;
          rx_div_last_q <= baud_last;
          rx_par_en_q   <= parity_enable;
          rx_par_type_q <= parity_type;
        end
      end else if (rx_sample) begin
        // Every later sample is a full bit after the previous one.
        rx_tick_cnt_q <= '0;
        unique case (rx_state_q)
          RX_START: begin
            rx_state_q   <= rx_line ? RX_IDLE : RX_DATA;
            rx_bit_cnt_q <= '0;
          end
          RX_DATA: begin
            rx_shift_q <= {rx_line, rx_shift_q[DATA_WIDTH-1:1]};
            if (rx_bit_cnt_q == LastBit) begin
              rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_cnt_q <= rx_bit_cnt_q + BitW'(1);
            end
          end
          RX_PARITY: begin
            rx_par_bit_q <= rx_line;
            rx_state_q   <= RX_STOP;
          end
          default: begin
            rx_state_q <= RX_IDLE;
          end
        endcase
      end
    end
  end

endmodule
